prbs_word_scheduler: RTL
========================

Name: prbs_word_scheduler

Overview:
Owns one PRBS31 LFSR with polynomial x^31 + x^28 + 1: feedback is lfsr[27] ^ lfsr[30], serial output is lfsr[30]. Shares the LFSR between NREQ requesters using round-robin arbitration. Each grant shifts the LFSR WORD_W times and delivers a WORD_W-bit word to the winning requester. Also sequences reseeding, so random-word consumers in the design never drive the LFSR directly.

Parameters:
NREQ, 2, number of requesters (2..8)
WORD_W, 8, bits per delivered word (1..31)
RST_SEED, 31'd1, LFSR value after reset; must be nonzero

Ports:
clk  input  1  clock
rst_n  input  1  reset
seed_valid  input  1  seed load request; held until seed_ack
seed_data  input  31  new LFSR state
seed_ack  output  1  one-cycle pulse: seed loaded
req  input  NREQ  per-requester word request (level)
gnt  output  NREQ  one-hot, one-cycle pulse: word_out valid for that requester
word_out  output  WORD_W  delivered word; holds last value between grants
busy  output  1  high in SHIFT and DELIVER

Interface note:
- Reset rst_n, asynchronous, active-high; clock clk.
- All outputs registered.

Behaviour:
- Reset values: lfsr=RST_SEED, state=IDLE, rr_ptr=0, gnt=0, seed_ack=0, word_out=0, busy=0, bit counter=0.
- A reset assertion mid-operation aborts the word in progress. No gnt is issued for it and rr_ptr returns to 0.
- FSM states: IDLE, SHIFT, DELIVER.
- IDLE, seed priority: seed_valid beats req. If seed_valid=1:
  - lfsr <= seed_data, or 31'd1 when seed_data==0 (the all-zero lock-up state is never loaded).
  - seed_ack=1 next cycle; stay in IDLE.
  - A seed request therefore costs exactly one cycle. Requests pending in the same cycle wait.
- IDLE, otherwise, if |req:
  - Winner = first set bit of req scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch the winner index; counter <= 0; go to SHIFT.
- SHIFT, each cycle:
  - shift register <= {shift[WORD_W-2:0], lfsr[30]} (capture, then step).
  - lfsr <= {lfsr[29:0], lfsr[27]^lfsr[30]}.
  - counter++.
  - After the WORD_W-th shift cycle, go to DELIVER.
  - The first captured bit ends up as MSB of word_out.
- DELIVER, one cycle:
  - word_out <= shift register; gnt[winner]=1 (registered, visible in this cycle).
  - rr_ptr <= (winner+1) mod NREQ; go to IDLE.
- Latency: req sampled in IDLE at cycle t gives gnt high in cycle t+WORD_W+1. Back-to-back grants are WORD_W+2 cycles apart.
- A grant is committed once SHIFT is entered. If req drops mid-SHIFT, gnt still pulses; the requester ignores it.
- A requester still holding req after its gnt counts as a new request and competes under round-robin.
- seed_valid during SHIFT/DELIVER is ignored (seed_ack=0). It is serviced at the next IDLE cycle, ahead of pending req.
- The LFSR advances only in SHIFT, so the sequence is deterministic from the seed regardless of idle time.
- Arithmetic: rr_ptr and winner are clog2(NREQ) bits, with wrap handled explicitly for non-power-of-2 NREQ. Counter is clog2(WORD_W+1) bits.

Decomposition:
- Shared package holds:
  - PRBS31 constants: LFSR_W=31, TAP_A=27, TAP_B=30, SAFE_SEED=31'd1.
  - The FSM state enum (IDLE/SHIFT/DELIVER).
- One natural sub-module: prbs31_step, a combinational next-state function (lfsr in, lfsr out, output bit). Reusable by any future checker block.

Test Plan:
- Reset, then seed_data=31'h7F80_0000, then req[0] held → seed_ack one cycle later; gnt[0] with word_out=8'hFF after 9 cycles; next grant gives word_out=8'h00.
- Seed 31'h5500_0000, single req[1] → word_out=8'hAA on gnt[1], exactly WORD_W+1 cycles after req is sampled.
- Seed 31'd0 → seed_ack pulses and the LFSR holds 31'd1. Four consecutive words are 8'h00, 8'h00, 8'h00, 8'h02 (never stuck at zero).
- req=2'b11 held from reset → gnt sequence 01,10,01,10, grants spaced 10 cycles apart. Repeat with NREQ=3, all requesting → order 0,1,2,0.
- seed_valid asserted mid-SHIFT together with a pending req[1] → current word delivered unchanged. seed_ack comes at the next IDLE cycle before req[1] is granted, and the following word reflects the new seed.
- rst_n pulsed mid-SHIFT → no gnt; all outputs at reset values. The next request yields the first word from RST_SEED (8'h00 for seed 1) to requester 0 when both request.

Source files
------------

// File: rtl/prbs_word_scheduler_pkg.sv
// Shared definitions for the PRBS31 word scheduler: LFSR geometry, taps, the
// lock-up-safe seed and the scheduler FSM state type.
package prbs_word_scheduler_pkg;

  // x^31 + x^28 + 1: feedback from bits 27 and 30, serial output from bit 30.
  localparam int unsigned LFSR_W = 31;
  localparam int unsigned TAP_A  = 27;
  localparam int unsigned TAP_B  = 30;

  // Substituted for an all-zero seed, which would lock the LFSR at zero.
  localparam logic [LFSR_W-1:0] SAFE_SEED = 31'd1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShift   = 2'd1,
    StDeliver = 2'd2
  } sched_state_e;

  // Map a requested seed to a loadable LFSR state.
  function automatic logic [LFSR_W-1:0] sanitize_seed(logic [LFSR_W-1:0] seed);
    return (seed == '0) ? SAFE_SEED : seed;
  endfunction

endpackage

// File: rtl/prbs_word_scheduler_if.sv
// Request/grant and reseed bundle between random-word consumers (master) and
// the PRBS word scheduler (slave).
interface prbs_word_scheduler_if
  import prbs_word_scheduler_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WORD_W = 8
);

  logic              seed_valid;
  logic [LFSR_W-1:0] seed_data;
  logic              seed_ack;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [WORD_W-1:0] word_out;
  logic              busy;

  modport master (
    output seed_valid,
    output seed_data,
    output req,
    input  seed_ack,
    input  gnt,
    input  word_out,
    input  busy
  );

  modport slave (
    input  seed_valid,
    input  seed_data,
    input  req,
    output seed_ack,
    output gnt,
    output word_out,
    output busy
  );

endinterface

// File: rtl/prbs_word_scheduler_step.sv
// One step of the PRBS31 LFSR as a pure combinational function: current state
// in, next state and serial output bit out. Kept separate so checkers can reuse it.
module prbs31_step
  import prbs_word_scheduler_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt,
  output logic              sout
);

  // Output is the MSB before the step; feedback enters at bit 0.
  always_comb begin
    sout = cur[TAP_B];
    nxt  = {cur[LFSR_W-2:0], cur[TAP_A] ^ cur[TAP_B]};
  end

endmodule

// File: rtl/prbs_word_scheduler.sv
// Shares one PRBS31 LFSR between NREQ requesters. Each round-robin grant shifts
// the LFSR WORD_W times and delivers the captured bits as one word; reseeding is
// sequenced here so that no consumer ever drives the LFSR directly.
module prbs_word_scheduler
  import prbs_word_scheduler_pkg::*;
#(
  parameter int unsigned       NREQ     = 2,
  parameter int unsigned       WORD_W   = 8,
  parameter logic [LFSR_W-1:0] RST_SEED = 31'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,  // active-high asynchronous reset
  prbs_word_scheduler_if.slave  bus
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WORD_W - 1);

  sched_state_e      state_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  winner_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [NREQ-1:0]   gnt_q;
  logic [WORD_W-1:0] word_q;
  logic              seed_ack_q;
  logic              busy_q;

  logic [LFSR_W-1:0] lfsr_step;
  logic              lfsr_bit;
  logic [WORD_W-1:0] shift_next;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  next_ptr;

  prbs31_step u_step (
    .cur  (lfsr_q),
    .nxt  (lfsr_step),
    .sout (lfsr_bit)
  );

  // Capture-then-step: the first captured bit drifts up to the word MSB.
  // The cast keeps the low WORD_W bits, which also covers WORD_W == 1.
  always_comb begin
    shift_next = WORD_W'({shift_q, lfsr_bit});
  end

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... with explicit wrap so that a
  // non-power-of-2 NREQ never indexes past the last requester. The scan runs
  // from the far end so the candidate nearest rr_ptr is the last one written.
  always_comb begin
    int   idx;
    logic [PTR_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    cand       = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(NREQ)) begin
        idx = idx - int'(NREQ);
      end
      cand = PTR_W'(idx);
      if (bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Pointer moves one past the requester just served, wrapping at NREQ-1.
  always_comb begin
    next_ptr = (winner_q == LAST_REQ) ? '0 : winner_q + PTR_W'(1);
  end

  // Scheduler FSM with registered outputs. gnt and word_out are loaded on the
  // edge that enters DELIVER so they are valid during the DELIVER cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= RST_SEED;
      shift_q    <= '0;
      cnt_q      <= '0;
      winner_q   <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      word_q     <= '0;
      seed_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q      <= '0;
      seed_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Reseed wins over requests and costs exactly one idle cycle.
          if (bus.seed_valid) begin
            lfsr_q     <= sanitize_seed(bus.seed_data);
            seed_ack_q <= 1'b1;
          end else if (pick_valid) begin
            winner_q <= pick_idx;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StShift;
          end
        end
        StShift: begin
          shift_q <= shift_next;
          lfsr_q  <= lfsr_step;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SHIFT) begin
            word_q  <= shift_next;
            gnt_q   <= NREQ'(1) << winner_q;
            state_q <= StDeliver;
          end
        end
        StDeliver: begin
          rr_ptr_q <= next_ptr;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.word_out = word_q;
  assign bus.seed_ack = seed_ack_q;
  assign bus.busy     = busy_q;

  // At most one requester is ever granted, and the LFSR never reaches zero.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst_n) $onehot0(gnt_q));
  a_lfsr_live:  assert property (@(posedge clk) disable iff (rst_n) lfsr_q != '0);
  a_ack_alone:  assert property (@(posedge clk) disable iff (rst_n)
                                 !(seed_ack_q && (gnt_q != '0)));

endmodule
